// File: rtl/ifetch_if.sv
// rtl/ifetch_if.sv - instruction memory and decode handshake bundle for ifetch
interface ifetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
    );
endinterface

// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch unit: single-outstanding memory requests feeding a small buffer
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic      clk,
    input  logic      reset,
    ifetch_if.master  bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, PEND, DROP} state_t;

    state_t        state;
    state_t        state_next;
    logic [31:0]   fetch_pc;
    logic [31:0]   req_pc;
    logic [31:0]   buf_data [DEPTH];
    logic [31:0]   buf_pc   [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [CW-1:0] credit_used;
    logic          push;
    logic          pop;
    logic          may_issue;
    logic          imem_req;
    logic          unused_low_bits;

    assign unused_low_bits = ^bus.redirect_pc[1:0];

    assign bus.imem_req    = imem_req;
    assign bus.imem_addr   = fetch_pc;
    assign bus.instr_valid = (count != '0);
    assign bus.instr       = buf_data[head];
    assign bus.instr_pc    = buf_pc[head];

    // A response completing this cycle frees the request slot, so a new
    // request may go out alongside it; this is what gives back-to-back fetch.
    always_comb begin
        state_next  = state;
        push        = 1'b0;
        may_issue   = 1'b0;
        pop         = bus.instr_valid && bus.instr_ready && !bus.redirect;
        credit_used = count + CW'(state == PEND) - CW'(pop);
        case (state)
            IDLE: may_issue = 1'b1;
            PEND: begin
                if (bus.imem_rvalid) begin
                    state_next = IDLE;
                    push       = !bus.redirect;
                    may_issue  = 1'b1;
                end else if (bus.redirect) begin
                    state_next = DROP;
                end
            end
            DROP: begin
                if (bus.imem_rvalid) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        imem_req = may_issue && !bus.redirect && !reset && (credit_used < CW'(DEPTH));
        if (imem_req && bus.imem_gnt) state_next = PEND;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            fetch_pc <= {RESET_PC[31:2], 2'b00};
            req_pc   <= {RESET_PC[31:2], 2'b00};
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            state <= state_next;
            if (bus.redirect) begin
                fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
            end else if (imem_req && bus.imem_gnt) begin
                fetch_pc <= fetch_pc + 32'd4;
                req_pc   <= fetch_pc;
            end
            if (bus.redirect) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) tail <= tail + PW'(1);
                if (pop)  head <= head + PW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Storage needs no reset: entries are only visible once count covers them.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            buf_data[tail] <= bus.imem_rdata;
            buf_pc[tail]   <= req_pc;
        end
    end
endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - randomized self-checking bench for ifetch against a queue reference model
module tb_ifetch;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    ifetch_if bus();

    ifetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    bit          mem_out;
    bit          mem_keep;
    logic [31:0] mem_addr;
    int          mem_wait;
    int          lat_min;
    int          lat_max;
    int          gnt_pct;
    int          gnt_block;

    logic [31:0] model_q[$];
    logic [31:0] exp_pc;
    logic [31:0] exp_fetch;
    bit          p_hold;
    logic [31:0] p_addr;

    logic        s_req, s_gnt, s_rvalid, s_valid, s_redirect, s_ready, s_reset;
    logic [31:0] s_addr, s_pc, s_instr, s_target;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        int occ;
        bus.imem_rvalid = mem_out && (mem_wait == 0);
        bus.imem_rdata  = bus.imem_rvalid ? word_of(mem_addr) : $urandom;
        #1;
        if (gnt_block > 0) bus.imem_gnt = 1'b0;
        else               bus.imem_gnt = bus.imem_req && ($urandom_range(0, 99) < gnt_pct);
        #1;
        s_req      = bus.imem_req;
        s_addr     = bus.imem_addr;
        s_gnt      = bus.imem_gnt;
        s_rvalid   = bus.imem_rvalid;
        s_valid    = bus.instr_valid;
        s_pc       = bus.instr_pc;
        s_instr    = bus.instr;
        s_redirect = bus.redirect;
        s_ready    = bus.instr_ready;
        s_reset    = reset;
        s_target   = {bus.redirect_pc[31:2], 2'b00};

        if (s_reset) begin
            chk("req_in_reset", s_req, 0);
            chk("valid_in_reset", s_valid, 0);
        end else begin
            chk("addr_align", s_addr[1:0], 0);
            chk("instr_valid", s_valid, model_q.size() != 0);
            if (model_q.size() != 0) begin
                chk("instr_pc", s_pc, model_q[0]);
                chk("instr_data", s_instr, word_of(model_q[0]));
            end
            if (s_redirect) chk("req_on_redirect", s_req, 0);
            if (p_hold && !s_redirect) begin
                chk("hold_req", s_req, 1);
                chk("hold_addr", s_addr, p_addr);
            end
            if (s_req) begin
                chk("req_addr", s_addr, exp_fetch);
                chk("one_outstanding", mem_out && !s_rvalid, 0);
                occ = model_q.size() + ((s_rvalid && mem_keep) ? 1 : 0) - ((s_valid && s_ready) ? 1 : 0);
                chk("credit", occ < DEPTH, 1);
            end
            if (s_valid && s_ready && !s_redirect) chk("seq_pc", s_pc, exp_pc);
        end

        @(posedge clk);
        if (s_reset) begin
            model_q.delete();
            mem_out   = 1'b0;
            exp_pc    = RESET_PC;
            exp_fetch = RESET_PC;
            p_hold    = 1'b0;
        end else begin
            if (s_valid && s_ready && !s_redirect && model_q.size() != 0) begin
                void'(model_q.pop_front());
                exp_pc = exp_pc + 32'd4;
            end
            if (s_rvalid) begin
                if (mem_keep && !s_redirect) model_q.push_back(mem_addr);
                mem_out = 1'b0;
            end else if (mem_out && mem_wait > 0) begin
                mem_wait--;
            end
            if (s_redirect) begin
                model_q.delete();
                exp_pc    = s_target;
                exp_fetch = s_target;
                if (mem_out) mem_keep = 1'b0;
            end
            if (s_req && s_gnt) begin
                mem_out   = 1'b1;
                mem_keep  = 1'b1;
                mem_addr  = s_addr;
                mem_wait  = $urandom_range(lat_min, lat_max);
                exp_fetch = exp_fetch + 32'd4;
            end
            p_hold = s_req && !s_gnt;
            p_addr = exp_fetch;
            if (gnt_block > 0) gnt_block--;
        end
        #2;
    endtask

    initial begin
        logic [31:0] hold_a;
        bit          found;

        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.instr_ready = 1'b0;
        mem_out = 1'b0; mem_keep = 1'b0; mem_addr = '0; mem_wait = 0;
        lat_min = 0; lat_max = 0; gnt_pct = 100; gnt_block = 0;
        p_hold = 1'b0; p_addr = '0;
        exp_pc = RESET_PC; exp_fetch = RESET_PC;

        @(posedge clk);
        #2;
        repeat (3) cycle();

        // Zero-wait memory after reset release: back-to-back fetch and delivery.
        reset = 1'b0;
        bus.instr_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            if (k < 3) begin
                chk($sformatf("boot_req%0d", k), s_req, 1);
                chk($sformatf("boot_addr%0d", k), s_addr, 32'(4 * k));
            end
            if (k >= 2) begin
                chk($sformatf("boot_valid%0d", k), s_valid, 1);
                chk($sformatf("boot_pc%0d", k), s_pc, 32'(4 * (k - 2)));
            end
        end

        // Decode stalls: buffer fills to DEPTH and requests stop.
        bus.instr_ready = 1'b0;
        repeat (10) cycle();
        chk("stall_req_low", s_req, 0);
        chk("stall_valid", s_valid, 1);
        chk("stall_depth", s_addr - s_pc, 32'(4 * DEPTH));
        bus.instr_ready = 1'b1;
        repeat (6) cycle();

        // Memory withholds grant for 5 cycles.
        gnt_block = 5;
        hold_a = exp_fetch;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk($sformatf("nogrant_req%0d", k), s_req, 1);
            chk($sformatf("nogrant_addr%0d", k), s_addr, hold_a);
        end
        repeat (4) cycle();

        // Redirect while a request is outstanding.
        lat_min = 2; lat_max = 2;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (mem_out && mem_wait > 0) found = 1'b1;
            else cycle();
        end
        chk("pend_found", found, 1);
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h0000_1003;
        cycle();
        bus.redirect = 1'b0;
        cycle();
        chk("flush_valid", s_valid, 0);
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            cycle();
            if (s_valid) found = 1'b1;
        end
        chk("redir_seen", found, 1);
        chk("redir_first_pc", s_pc, 32'h0000_1000);
        repeat (4) cycle();

        // Redirect coincident with a response and a pop.
        lat_min = 0; lat_max = 0;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (mem_out && mem_wait == 0 && bus.instr_valid) found = 1'b1;
            else cycle();
        end
        chk("coinc_found", found, 1);
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h0000_2000;
        cycle();
        bus.redirect = 1'b0;
        chk("coinc_req_low", s_req, 0);
        chk("coinc_pop", s_valid, 1);
        cycle();
        chk("coinc_next_req", s_req, 1);
        chk("coinc_next_addr", s_addr, 32'h0000_2000);
        chk("coinc_flushed", s_valid, 0);
        repeat (4) cycle();

        // Address wrap at the top of memory.
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFE;
        cycle();
        bus.redirect = 1'b0;
        cycle();
        chk("wrap_top_addr", s_addr, 32'hFFFF_FFFC);
        chk("wrap_top_gnt", s_req && s_gnt, 1);
        cycle();
        chk("wrap_next_addr", s_addr, 32'h0000_0000);
        repeat (5) cycle();

        // Random traffic against the reference model.
        lat_min = 0; lat_max = 3; gnt_pct = 60;
        for (int k = 0; k < 800; k++) begin
            bus.instr_ready = ($urandom_range(0, 3) != 0);
            bus.redirect    = ($urandom_range(0, 19) == 0);
            bus.redirect_pc = $urandom;
            cycle();
        end
        bus.redirect = 1'b0;
        bus.instr_ready = 1'b1;
        repeat (10) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
